// File: rtl/bridge_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bridge_req_arbiter
// Purpose  : Round-robin arbiter sharing the bridge_driver request channel
//            between NUM_REQ requesters. Snapshots the winner, issues a
//            one-cycle valid pulse downstream, tracks it to completion and
//            routes progress/result/response back to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  // Requester side
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*16-1:0]    in_word,
  input  logic [NUM_REQ*128-1:0]   in_param,
  output logic [NUM_REQ-1:0]       in_grant,
  output logic [NUM_REQ-1:0]       in_done,
  output logic [15:0]              in_result,
  output logic [127:0]             in_response,
  output logic [15:0]              in_progress,
  // Downstream (bridge_driver req port) side
  output logic                     out_valid,
  output logic [15:0]              out_word,
  output logic [127:0]             out_param,
  input  logic                     out_done,
  input  logic [15:0]              out_result,
  input  logic [127:0]             out_response,
  input  logic [15:0]              out_progress
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETIRE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 valid_q, valid_d;
  logic [15:0]          word_q, word_d;
  logic [127:0]         param_q, param_d;
  logic [15:0]          result_q, result_d;
  logic [127:0]         response_q, response_d;
  logic [15:0]          progress_q, progress_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && in_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and datapath updates for the grant/issue/wait/retire sequence.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    done_d     = '0;
    valid_d    = 1'b0;
    word_d     = word_q;
    param_d    = param_q;
    result_d   = result_q;
    response_d = response_q;
    progress_d = progress_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          last_d     = win_idx;
          grant_d    = NUM_REQ'(1) << win_idx;
          word_d     = in_word[int'(win_idx)*16 +: 16];
          param_d    = in_param[int'(win_idx)*128 +: 128];
          progress_d = '0;
          valid_d    = 1'b1;       // registered so it is high only during ISSUE
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        progress_d = out_progress;
        if (out_done) begin
          result_d   = out_result;
          response_d = out_response;
          done_d     = grant_q;      // completion pulse visible during RETIRE
          state_d    = S_RETIRE;
        end
      end
      S_RETIRE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      done_q     <= '0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      param_q    <= '0;
      result_q   <= '0;
      response_q <= '0;
      progress_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
      param_q    <= param_d;
      result_q   <= result_d;
      response_q <= response_d;
      progress_q <= progress_d;
    end
  end

  assign in_grant    = grant_q;
  assign in_done     = done_q;
  assign in_result   = result_q;
  assign in_response = response_q;
  assign in_progress = progress_q;
  assign out_valid   = valid_q;
  assign out_word    = word_q;
  assign out_param   = param_q;

endmodule
`default_nettype wire

// File: doc/bridge_req_arbiter.md
# bridge_req_arbiter

Round-robin arbiter that shares the single core-to-host request channel of `bridge_driver` (the `req` side) between `NUM_REQ` independent requesters. It snapshots the winning request and issues it downstream as a one-cycle `valid` pulse. It then tracks the transaction until `done` and routes `progress`, `result` and `response` back to the granted requester only. It sits between core-side command sources (save-state, data-slot, etc.) and `bridge_driver`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters, 2..8
- `IDX_W`, `$clog2(NUM_REQ)`, grant index width (derived, not overridden)

Ports:
- `clk`  in  1  bridge clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  NUM_REQ  per-requester request; held high until that requester's `in_done`
- `in_word`  in  NUM_REQ×16  per-requester command word; slice i = bits [16i+15:16i]
- `in_param`  in  NUM_REQ×128  per-requester parameter block; slice i = bits [128i+127:128i]
- `in_grant`  out  NUM_REQ  one-hot; bit i high while requester i's transaction is in flight
- `in_done`  out  NUM_REQ  one-hot single-cycle completion pulse
- `in_result`  out  16  result word; valid while `in_done` is high
- `in_response`  out  128  response block; valid while `in_done` is high
- `in_progress`  out  16  last downstream progress; meaningful while `in_grant` is nonzero
- `out_valid`  out  1  request to `bridge_driver` req port
- `out_word`  out  16  command word to downstream
- `out_param`  out  128  parameters to downstream
- `out_done`  in  1  downstream completion pulse
- `out_result`  in  16  downstream result
- `out_response`  in  128  downstream response
- `out_progress`  in  16  downstream progress

## Operation
- States:
  - IDLE: no grant.
    - If any `in_valid` is high, pick the winner, capture its `in_word`/`in_param` into `out_word`/`out_param`, set `in_grant`, clear `in_progress`, then go to ISSUE.
  - ISSUE: `out_valid`=1 for exactly this cycle, then go to WAIT.
  - WAIT: `out_valid`=0. Register `out_progress` into `in_progress` every cycle.
    - On `out_done`: register `out_result`/`out_response` into `in_result`/`in_response`, then go to RETIRE.
  - RETIRE: `in_done[g]`=1 for this cycle; `in_grant` cleared at the end of the cycle; then go to IDLE.
- Round-robin selection:
  - Search starts at `last+1` (mod NUM_REQ); first requester with `in_valid` high wins.
  - `last` updates to the winner at grant time.
  - After reset, `last`=NUM_REQ-1, so requester 0 has top priority.
- Snapshot: word and param are captured at grant. Requester changes after grant have no effect on the transaction in flight.
- `out_valid` is a pulse, never a level. `bridge_driver` re-accepts a held valid after its DONE state, so the arbiter must never hold it.
- `in_valid` dropped during ISSUE/WAIT: ignored. The transaction completes and `in_done` still pulses for that requester.
- `out_done` in IDLE/ISSUE/RETIRE: ignored.
- `in_result`/`in_response` hold their values after RETIRE until the next completion.
- Reset values:
  - state IDLE, `last`=NUM_REQ-1
  - `out_valid`=0, `in_grant`=0, `in_done`=0
  - `in_result`/`in_progress`=0, `in_response`=0, `out_word`=0, `out_param`=0
- Reset mid-transaction returns the arbiter to IDLE. It does not abort downstream. Assert `reset` together with the downstream reset; the arbiter must not issue again until downstream is idle.

## Timing
- Request seen high in IDLE at cycle 0 → ISSUE at cycle 1 (`out_valid`=1) → WAIT from cycle 2.
- `out_done` at cycle D → `in_done` at cycle D+1 → IDLE at D+2.
- Earliest next `out_valid` is D+3. Minimum spacing between issues is ≥3 cycles after any `out_done`.
- Requester contract: deassert `in_valid` on the edge that samples `in_done`. The arbiter samples `in_valid` again in IDLE, one cycle after RETIRE.
- `in_progress` lags `out_progress` by one cycle.
- No combinational path from any `in_*` input to any `out_*` output, or the reverse.

## Test plan
- Single request: `in_valid[2]`=1, word=16'h0042, param=128'h1234. Expect `out_valid` one cycle with those values. Drive `out_done` with result=16'h0007, response=128'hABCD. Expect `in_done`=4'b0100 next cycle with result 16'h0007 and response 128'hABCD.
- Round robin: all four valid from reset, each retired normally. Expect grant order 0,1,2,3,0, with `out_valid` pulses spaced ≥3 cycles after each `out_done`.
- Snapshot: change `in_word[1]` from 16'h0010 to 16'h0020 one cycle after grant. Expect `out_word` to stay 16'h0010; requester 1's `in_done` still fires.
- Progress routing: hold WAIT and step `out_progress` through 1,2,3. Expect `in_progress` to follow one cycle later, with only the granted bit set in `in_grant`.
- Stray events: `out_done` pulse in IDLE → no `in_done`, no state change. `in_valid` dropped mid-WAIT → `in_done` still pulses on `out_done`.
- Reset in WAIT: assert `reset` one cycle. Expect all outputs at reset values and the next grant to go to requester 0 if it is valid.
